id_stage: RTL and testbench

Instruction-decode stage of the five-stage pipeline, directly downstream of instruction fetch. It holds the IF/ID pipeline register, the 32×32 register file with WB write-through, and the RV32I immediate decode. It resolves BEQ/BNE/JAL/JALR in ID and detects hazards. It drives the fetch stage's `Branch`, `Jump`, `JumpAddr` and `IFWrite` controls and presents decoded operands to EX.

---
 rtl/id_stage.sv | 180 ++++++++++++++++++
 tb/tb_id_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of a five-stage RV32I pipeline.
//
// Holds the IF/ID pipeline register, the 32x32 register file with
// write-through from WB, and the immediate decoder. BEQ/BNE/JAL/JALR are
// resolved here, and load-use and control-operand hazards stall the front end.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   Instruction_if, PC         fetched instruction and its PC
//   IFWrite                    PC / IF-ID write enable (0 = stall)
//   Branch, Jump, JumpAddr     redirect request and target for fetch
//   RegWrite_ex, MemRead_ex,
//   rd_ex                      destination info of the instruction in EX
//   RegWrite_mem, rd_mem       destination info of the instruction in MEM
//   RegWrite_wb, rd_wb,
//   wdata_wb                   register-file write port
//   id_valid                   decoded outputs carry a real instruction
//   PC_id, Instruction_id      IF/ID register contents
//   rs1, rs2, rd               register fields of the decoded instruction
//   rs1_data, rs2_data         register read data (with WB write-through)
//   imm                        sign-extended immediate
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] PC,
  output logic        IFWrite,
  output logic        Branch,
  output logic        Jump,
  output logic [31:0] JumpAddr,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic [4:0]  rd_ex,
  input  logic        RegWrite_mem,
  input  logic [4:0]  rd_mem,
  input  logic        RegWrite_wb,
  input  logic [4:0]  rd_wb,
  input  logic [31:0] wdata_wb,
  output logic        id_valid,
  output logic [31:0] PC_id,
  output logic [31:0] Instruction_id,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        wb_we;
  logic        uses1, uses2;
  logic        is_branch, is_jal, is_jalr;
  logic        match_ex, match_mem;
  logic        load_use, ctrl_haz, stall, active, taken;

  function automatic logic [31:0] imm_decode(input logic [31:0] ins);
    logic [31:0] v;
    v = '0;
    case (ins[6:0])
      OP_IMM, OP_LOAD, OP_JALR: v = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                 v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:                v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         v = {ins[31:12], 12'b0};
      OP_JAL:                   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:                  v = '0;
    endcase
    return v;
  endfunction

  // ---- ID stage: decode of the IF/ID register ----
  assign opcode         = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign rs1            = instr_q[19:15];
  assign rs2            = instr_q[24:20];
  assign rd             = instr_q[11:7];
  assign PC_id          = pc_q;
  assign Instruction_id = instr_q;
  assign imm            = imm_decode(instr_q);

  // Register read with same-cycle WB bypass; x0 is hard-wired to zero.
  assign wb_we    = RegWrite_wb && (rd_wb != 5'd0);
  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : ((wb_we && rd_wb == rs1) ? wdata_wb : regs[rs1]);
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : ((wb_we && rd_wb == rs2) ? wdata_wb : regs[rs2]);

  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  // Which source fields are real register reads (x0 never creates a hazard).
  assign uses1 = (rs1 != 5'd0) &&
                 (opcode == OP_IMM || opcode == OP_LOAD || opcode == OP_JALR ||
                  opcode == OP_STORE || opcode == OP_BRANCH || opcode == OP_REG);
  assign uses2 = (rs2 != 5'd0) &&
                 (opcode == OP_STORE || opcode == OP_BRANCH || opcode == OP_REG);

  assign match_ex  = (rd_ex != 5'd0) && ((uses1 && rs1 == rd_ex) || (uses2 && rs2 == rd_ex));
  assign match_mem = (rd_mem != 5'd0) && ((uses1 && rs1 == rd_mem) || (uses2 && rs2 == rd_mem));

  // A branch/JALR compares operands in ID, so it must wait until any producer
  // has left MEM; WB write-through then supplies the value.
  assign load_use = MemRead_ex && match_ex;
  assign ctrl_haz = (is_branch || is_jalr) &&
                    ((RegWrite_ex && match_ex) || (RegWrite_mem && match_mem));
  assign stall    = valid_q && (load_use || ctrl_haz);
  assign active   = valid_q && !stall;

  assign IFWrite  = !stall;
  assign id_valid = active;

  always_comb begin
    Branch   = 1'b0;
    Jump     = 1'b0;
    JumpAddr = pc_q + 32'd4;
    if (active) begin
      if (is_branch) begin
        case (funct3)
          3'b000:  Branch = (rs1_data == rs2_data);
          3'b001:  Branch = (rs1_data != rs2_data);
          default: Branch = 1'b0;
        endcase
        if (Branch) JumpAddr = pc_q + imm;
      end else if (is_jal) begin
        Jump     = 1'b1;
        JumpAddr = pc_q + imm;
      end else if (is_jalr) begin
        Jump     = 1'b1;
        JumpAddr = (rs1_data + imm) & ~32'd1;
      end
    end
  end

  assign taken = Branch || Jump;

  // ---- IF/ID register: reset > stall (hold) > flush > load ----
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q <= PC;
      if (taken) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else begin
        instr_q <= Instruction_if;
        valid_q <= 1'b1;
      end
    end
  end

  // ---- WB stage: register-file write ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[rd_wb] <= wdata_wb;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed test-plan sequence followed by
// randomized traffic, both scored against a behavioural model.
module tb_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction_if, PC;
  logic        IFWrite, Branch, Jump;
  logic [31:0] JumpAddr;
  logic        RegWrite_ex, MemRead_ex;
  logic [4:0]  rd_ex;
  logic        RegWrite_mem;
  logic [4:0]  rd_mem;
  logic        RegWrite_wb;
  logic [4:0]  rd_wb;
  logic [31:0] wdata_wb;
  logic        id_valid;
  logic [31:0] PC_id, Instruction_id;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, imm;

  id_stage #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .PC(PC),
    .IFWrite(IFWrite), .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .rd_ex(rd_ex),
    .RegWrite_mem(RegWrite_mem), .rd_mem(rd_mem),
    .RegWrite_wb(RegWrite_wb), .rd_wb(rd_wb), .wdata_wb(wdata_wb),
    .id_valid(id_valid), .PC_id(PC_id), .Instruction_id(Instruction_id),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] ins, pc;
    logic        we_ex, mr_ex;
    logic [4:0]  rd_ex;
    logic        we_mem;
    logic [4:0]  rd_mem;
    logic        we_wb;
    logic [4:0]  rd_wb;
    logic [31:0] wd_wb;
  } in_t;

  typedef struct {
    logic        vld, ifw, br, jp;
    logic [31:0] ja, pc, ins;
    logic [4:0]  r1, r2, rdf;
    logic [31:0] d1, d2, imm;
  } exp_t;

  int n_err = 0;
  int n_chk = 0;
  bit done  = 0;
  exp_t sb[$];

  // Behavioural model state: what sits in ID, and the architectural registers.
  logic        m_vld;
  logic [31:0] m_pc, m_ins;
  logic [31:0] m_regs [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic signed [31:0] s;
    s = $signed(v << (32 - bits)) >>> (32 - bits);
    return s;
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] i);
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return sext({20'd0, i[31:20]}, 12);
      7'b0100011: return sext({20'd0, i[31:25], i[11:7]}, 12);
      7'b1100011: return sext({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
      7'b0110111, 7'b0010111: return i & 32'hFFFFF000;
      7'b1101111: return sext({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input in_t x);
    if (a == 0) return 32'd0;
    if (x.we_wb && x.rd_wb == a) return x.wd_wb;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    m_vld = 0; m_pc = 0; m_ins = NOP;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  // Produce this cycle's expected outputs, then advance to the next cycle.
  task automatic model_step(input in_t x, output exp_t e);
    logic [6:0] op;
    logic [4:0] a1, a2;
    logic reads1, reads2, hit_ex, hit_mem, stall;
    op = m_ins[6:0]; a1 = m_ins[19:15]; a2 = m_ins[24:20];
    e.pc = m_pc; e.ins = m_ins; e.r1 = a1; e.r2 = a2; e.rdf = m_ins[11:7];
    e.d1 = model_read(a1, x); e.d2 = model_read(a2, x);
    e.imm = model_imm(m_ins);
    reads1 = (a1 != 0) && (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110011});
    reads2 = (a2 != 0) && (op inside {7'b0100011, 7'b1100011, 7'b0110011});
    hit_ex  = x.rd_ex != 0 && ((reads1 && a1 == x.rd_ex) || (reads2 && a2 == x.rd_ex));
    hit_mem = x.rd_mem != 0 && ((reads1 && a1 == x.rd_mem) || (reads2 && a2 == x.rd_mem));
    stall = m_vld && ((x.mr_ex && hit_ex) ||
            ((op == 7'b1100011 || op == 7'b1100111) && ((x.we_ex && hit_ex) || (x.we_mem && hit_mem))));
    e.ifw = !stall;
    e.vld = m_vld && !stall;
    e.br = 0; e.jp = 0; e.ja = m_pc + 4;
    if (e.vld) begin
      if (op == 7'b1100011) begin
        if (m_ins[14:12] == 3'd0) e.br = (e.d1 == e.d2);
        else if (m_ins[14:12] == 3'd1) e.br = (e.d1 != e.d2);
        if (e.br) e.ja = m_pc + e.imm;
      end else if (op == 7'b1101111) begin
        e.jp = 1; e.ja = m_pc + e.imm;
      end else if (op == 7'b1100111) begin
        e.jp = 1; e.ja = (e.d1 + e.imm) & 32'hFFFFFFFE;
      end
    end
    if (x.rst) model_reset();
    else begin
      if (x.we_wb && x.rd_wb != 0) m_regs[x.rd_wb] = x.wd_wb;
      if (!stall) begin
        m_pc = x.pc;
        if (e.br || e.jp) begin m_ins = NOP; m_vld = 0; end
        else begin m_ins = x.ins; m_vld = 1; end
      end
    end
  endtask

  function automatic in_t idle(input logic [31:0] ins, input logic [31:0] pc);
    in_t x;
    x.rst = 0; x.ins = ins; x.pc = pc;
    x.we_ex = 0; x.mr_ex = 0; x.rd_ex = 0; x.we_mem = 0; x.rd_mem = 0;
    x.we_wb = 0; x.rd_wb = 0; x.wd_wb = 0;
    return x;
  endfunction

  task automatic drive(input in_t x);
    exp_t e;
    @(posedge clk);
    #1;
    reset = x.rst; Instruction_if = x.ins; PC = x.pc;
    RegWrite_ex = x.we_ex; MemRead_ex = x.mr_ex; rd_ex = x.rd_ex;
    RegWrite_mem = x.we_mem; rd_mem = x.rd_mem;
    RegWrite_wb = x.we_wb; rd_wb = x.rd_wb; wdata_wb = x.wd_wb;
    model_step(x, e);
    sb.push_back(e);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                        input logic [4:0] d, input logic [6:0] op);
    return {im, s1, 3'b000, d, op};
  endfunction
  function automatic logic [31:0] enc_add(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {7'd0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [2:0] f3);
    return {off[12], off[10:5], s2, s1, f3, off[4:1], off[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] d);
    return {off[20], off[10:1], off[11], off[19:12], d, 7'b1101111};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: r[6:0] = 7'b0010011;
      1: r[6:0] = 7'b0000011;
      2: r[6:0] = 7'b1100111;
      3: r[6:0] = 7'b0100011;
      4, 5, 6: begin
        r[6:0] = 7'b1100011;
        r[14:12] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
      end
      7: r[6:0] = 7'b0110111;
      8: r[6:0] = 7'b0010111;
      9: r[6:0] = 7'b1101111;
      10: r[6:0] = 7'b0110011;
      default: r[6:0] = 7'b1110011;
    endcase
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    r[11:7]  = 5'($urandom_range(0, 7));
    return r;
  endfunction

  // Monitor: every cycle the DUT presents a decode result; score it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("id_valid", 32'(id_valid), 32'(e.vld));
        chk("IFWrite", 32'(IFWrite), 32'(e.ifw));
        chk("Branch", 32'(Branch), 32'(e.br));
        chk("Jump", 32'(Jump), 32'(e.jp));
        chk("JumpAddr", JumpAddr, e.ja);
        chk("PC_id", PC_id, e.pc);
        chk("Instruction_id", Instruction_id, e.ins);
        chk("rs1", 32'(rs1), 32'(e.r1));
        chk("rs2", 32'(rs2), 32'(e.r2));
        chk("rd", 32'(rd), 32'(e.rdf));
        chk("rs1_data", rs1_data, e.d1);
        chk("rs2_data", rs2_data, e.d2);
        chk("imm", imm, e.imm);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t x;
    reset = 1; Instruction_if = NOP; PC = 0;
    RegWrite_ex = 0; MemRead_ex = 0; rd_ex = 0; RegWrite_mem = 0; rd_mem = 0;
    RegWrite_wb = 0; rd_wb = 0; wdata_wb = 0;
    model_reset();

    x = idle(NOP, 0); x.rst = 1;
    drive(x);
    drive(x);
    drive(idle(enc_i(12'd7, 0, 1, 7'b0010011), 32'h0));
    @(negedge clk); chk("reset_release_id_valid", 32'(id_valid), 0);
    drive(idle(enc_i(12'd7, 0, 2, 7'b0010011), 32'h4));
    @(negedge clk); chk("first_valid", 32'(id_valid), 1); chk("first_pc", PC_id, 32'h0);
    x = idle(enc_add(6, 5, 0), 32'h8); x.we_wb = 1; x.rd_wb = 1; x.wd_wb = 7;
    drive(x);
    x = idle(NOP, 32'hC); x.we_wb = 1; x.rd_wb = 5; x.wd_wb = 32'hDEADBEEF;
    drive(x);
    @(negedge clk); chk("wb_write_through", rs1_data, 32'hDEADBEEF);
    x = idle(enc_add(4, 3, 1), 32'h10); x.we_wb = 1; x.rd_wb = 2; x.wd_wb = 7;
    drive(x);
    x = idle(NOP, 32'h14); x.we_ex = 1; x.mr_ex = 1; x.rd_ex = 3;
    x.we_wb = 1; x.rd_wb = 0; x.wd_wb = 32'hFFFFFFFF;
    drive(x);
    @(negedge clk); chk("load_use_ifwrite", 32'(IFWrite), 0); chk("load_use_valid", 32'(id_valid), 0);
    drive(idle(NOP, 32'h14));
    @(negedge clk); chk("load_use_hold", Instruction_id, enc_add(4, 3, 1));
    drive(idle(enc_b(13'd16, 1, 2, 3'b000), 32'h20));
    drive(idle(NOP, 32'h24));
    @(negedge clk); chk("beq_taken", 32'(Branch), 1); chk("beq_target", JumpAddr, 32'h30);
    drive(idle(enc_b(13'd16, 1, 2, 3'b001), 32'h30));
    @(negedge clk); chk("flush_valid", 32'(id_valid), 0); chk("flush_nop", Instruction_id, NOP);
    drive(idle(enc_j(21'h1FFFF8, 0), 32'h40));
    @(negedge clk); chk("bne_not_taken", 32'(Branch), 0);
    x = idle(NOP, 32'h44); x.we_wb = 1; x.rd_wb = 9; x.wd_wb = 32'h100;
    drive(x);
    @(negedge clk); chk("jal_jump", 32'(Jump), 1); chk("jal_target", JumpAddr, 32'h38);
    drive(idle(enc_i(12'd3, 9, 0, 7'b1100111), 32'h38));
    drive(idle(NOP, 32'h3C));
    @(negedge clk); chk("jalr_target", JumpAddr, 32'h102);
    drive(idle(enc_b(13'd8, 7, 2, 3'b000), 32'h50));
    x = idle(NOP, 32'h54); x.we_ex = 1; x.rd_ex = 7;
    drive(x);
    @(negedge clk); chk("ctrl_haz_ex_branch", 32'(Branch), 0); chk("ctrl_haz_ex_ifwrite", 32'(IFWrite), 0);
    x = idle(NOP, 32'h54); x.we_mem = 1; x.rd_mem = 7;
    drive(x);
    @(negedge clk); chk("ctrl_haz_mem_ifwrite", 32'(IFWrite), 0);
    x = idle(NOP, 32'h54); x.we_wb = 1; x.rd_wb = 7; x.wd_wb = 7;
    drive(x);
    @(negedge clk); chk("ctrl_haz_release", 32'(IFWrite), 1); chk("ctrl_haz_branch", 32'(Branch), 1);
    chk("ctrl_haz_target", JumpAddr, 32'h58);
    drive(idle(NOP, 32'h58));

    for (int n = 0; n < 800; n++) begin
      x = idle(rand_instr(), {22'd0, 8'($urandom), 2'b00});
      x.rst    = ($urandom_range(0, 63) == 0);
      x.we_ex  = ($urandom_range(0, 2) == 0);
      x.mr_ex  = ($urandom_range(0, 4) == 0);
      x.rd_ex  = 5'($urandom_range(0, 7));
      x.we_mem = ($urandom_range(0, 2) == 0);
      x.rd_mem = 5'($urandom_range(0, 7));
      x.we_wb  = ($urandom_range(0, 1) == 0);
      x.rd_wb  = 5'($urandom_range(0, 7));
      x.wd_wb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      drive(x);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    done = 1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
